stack_sequencer: RTL and testbench

Initiator-side controller for the CPU's 8-bit LIFO data stack. It accepts one stack-arithmetic command at a time from the multicycle control unit and drives the stack's push/pop/tos strobes in the correct order. Operands are captured from the stack's registered output, the ALU result is computed internally and pushed back, and completion is reported with a one-cycle `done` pulse. It sits between the control FSM and the stack; nothing else drives the stack strobes.

---
 rtl/stack_sequencer_if.sv | 20 ++
 rtl/stack_sequencer.sv | 161 ++++++++++++++++
 tb/tb_stack_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_if.sv
// Strobe/data bus between the stack sequencer (master) and the LIFO stack (slave).
interface stack_sequencer_if #(
  parameter int W = 8
);
  logic [W-1:0] stk_din;
  logic         stk_push;
  logic         stk_pop;
  logic         stk_tos;
  logic [W-1:0] stk_dout;

  modport master (
    output stk_din, stk_push, stk_pop, stk_tos,
    input  stk_dout
  );

  modport slave (
    input  stk_din, stk_push, stk_pop, stk_tos,
    output stk_dout
  );
endinterface

// File: rtl/stack_sequencer.sv
// Sequences one stack-arithmetic command at a time onto an 8-bit LIFO stack.
// Optional underflow/overflow guarding and depth tracking: STACK_SEQ_DEPTH_CHECK_EN.
module stack_sequencer #(
  parameter int W     = 8,
  parameter int DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [W-1:0]          imm,
  output logic                  busy,
  output logic                  done,
  output logic [W-1:0]          result,
  output logic                  err,
  output logic [5:0]            depth,
  stack_sequencer_if.master     stk
);

  typedef enum logic [2:0] {IDLE, POP1, POP2, CAP, PUSH, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_PUSHI, OP_POP, OP_TOS, OP_RSVD
  } op_t;

  if (DEPTH < 1 || DEPTH > 63) begin : g_bad_depth
    $error("DEPTH must fit the 6-bit depth port");
  end

  state_t       state, state_n;
  op_t          op_q, op_in;
  logic [W-1:0] imm_q, a_q, b_q, alu, res_n;
  logic         err_n;
  logic         bin_q, bin_in;
  logic         lack2, lack1, full;

  assign op_in  = op_t'(op);
  assign bin_q  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND);
  assign bin_in = (op_in == OP_ADD) || (op_in == OP_SUB) || (op_in == OP_AND);

`ifdef STACK_SEQ_DEPTH_CHECK_EN
  logic [5:0] depth_q;

  assign lack2 = (depth_q < 6'd2);
  assign lack1 = (depth_q == '0);
  assign full  = (depth_q == 6'(DEPTH));
  assign depth = depth_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
    end else if (stk.stk_push && !full) begin
      depth_q <= depth_q + 6'd1;
    end else if (stk.stk_pop && !lack1) begin
      depth_q <= depth_q - 6'd1;
    end
  end
`else
  assign lack2 = 1'b0;
  assign lack1 = 1'b0;
  assign full  = 1'b0;
  assign depth = '0;
`endif

  always_comb begin
    unique case (op_q)
      OP_ADD:  alu = a_q + b_q;
      OP_SUB:  alu = a_q - b_q;
      OP_AND:  alu = a_q & b_q;
      OP_NOT:  alu = ~b_q;
      default: alu = imm_q;
    endcase
  end

  // res_n/err_n default to the held values, so they only move on entry to DONE.
  always_comb begin
    state_n      = state;
    busy         = (state != IDLE);
    done         = 1'b0;
    stk.stk_push = 1'b0;
    stk.stk_pop  = 1'b0;
    stk.stk_tos  = 1'b0;
    stk.stk_din  = '0;
    res_n        = result;
    err_n        = err;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (op_in == OP_RSVD) begin
            state_n = DONE;
            err_n   = 1'b1;
          end else if (op_in == OP_PUSHI) begin
            state_n = full ? DONE : PUSH;
            err_n   = full;
          end else if (bin_in ? lack2 : lack1) begin
            state_n = DONE;
            err_n   = 1'b1;
          end else begin
            state_n = POP1;
          end
        end
      end
      POP1: begin
        if (op_q == OP_TOS) stk.stk_tos = 1'b1;
        else                stk.stk_pop = 1'b1;
        state_n = bin_q ? POP2 : CAP;
      end
      POP2: begin
        stk.stk_pop = 1'b1;
        state_n     = CAP;
      end
      CAP: begin
        if (op_q == OP_POP || op_q == OP_TOS) begin
          res_n   = stk.stk_dout;
          err_n   = 1'b0;
          state_n = DONE;
        end else begin
          state_n = PUSH;
        end
      end
      PUSH: begin
        stk.stk_push = 1'b1;
        stk.stk_din  = alu;
        res_n        = alu;
        err_n        = 1'b0;
        state_n      = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_ADD;
      imm_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      result <= res_n;
      err    <= err_n;
      if (state == IDLE && start) begin
        op_q  <= op_in;
        imm_q <= imm;
      end
      // First pop returns the former top (B); for binary ops the deeper entry (A) follows.
      if (state == POP2) b_q <= stk.stk_dout;
      if (state == CAP) begin
        if (bin_q) a_q <= stk.stk_dout;
        else       b_q <= stk.stk_dout;
      end
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural LIFO stack attached.
module tb_stack_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op_i = '0;
  logic [7:0] imm_i = '0;
  logic       busy, done, err;
  logic [7:0] result;
  logic [5:0] depth;

  int n_chk = 0;
  int n_fail = 0;
  int viol = 0;
  int n_done = 0;
  logic [15:0] seq = '0;

  stack_sequencer_if #(.W(8)) sif ();

  stack_sequencer #(.W(8), .DEPTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op_i),
    .imm    (imm_i),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err),
    .depth  (depth),
    .stk    (sif.master)
  );

  always #5 clk = ~clk;

  // Behavioural stack: registered output valid the cycle after pop/tos.
  logic [7:0] mem [0:63];
  int sp;
  always @(posedge clk) begin
    if (rst) begin
      sp <= 0;
      sif.stk_dout <= '0;
    end else if (sif.stk_push) begin
      if (sp < 64) mem[sp] <= sif.stk_din;
      sp <= sp + 1;
    end else if (sif.stk_pop) begin
      if (sp > 0) begin
        sif.stk_dout <= mem[sp-1];
        sp <= sp - 1;
      end
    end else if (sif.stk_tos) begin
      if (sp > 0) sif.stk_dout <= mem[sp-1];
    end
  end

  // Protocol monitor: one strobe at a time, din quiet without push,
  // result only moves with done, done is a single-cycle pulse.
  logic [7:0] prev_res = '0;
  logic       rst_q = 1'b1;
  logic       done_q = 1'b0;
  logic [1:0] code;
  always @(negedge clk) begin
    if (int'(sif.stk_push) + int'(sif.stk_pop) + int'(sif.stk_tos) > 1) viol++;
    if (!sif.stk_push && sif.stk_din != 8'h00) viol++;
    code = sif.stk_push ? 2'd1 : sif.stk_pop ? 2'd2 : sif.stk_tos ? 2'd3 : 2'd0;
    if (code != 2'd0) seq = {seq[13:0], code};
    if (!rst && !rst_q && result != prev_res && !done) viol++;
    if (done && done_q) viol++;
    if (done) n_done++;
    done_q   = done;
    rst_q    = rst;
    prev_res = result;
  end

  function automatic int dexp(input int d);
`ifdef STACK_SEQ_DEPTH_CHECK_EN
    return d;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_result"}, result, 0);
    check({name, "_err"}, err, 0);
    check({name, "_depth"}, depth, 0);
    check({name, "_strobes"}, {sif.stk_push, sif.stk_pop, sif.stk_tos}, 0);
    check({name, "_din"}, sif.stk_din, 0);
  endtask

  // Issues one command; start is sampled at edge 0, latency counted in cycles.
  task automatic run_cmd(input string name, input logic [2:0] o, input logic [7:0] im,
                         input bit poke, input logic [7:0] eres, input bit eerr,
                         input int elat, input int edep, input logic [15:0] eseq);
    int lat;
    @(negedge clk);
    start = 1'b1; op_i = o; imm_i = im; seq = '0;
    @(negedge clk);
    check({name, "_busy"}, busy, 1);
    if (poke) begin
      start = 1'b1; op_i = 3'b101; imm_i = 8'h99;
    end else begin
      start = 1'b0;
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check({name, "_latency"}, lat, elat);
    check({name, "_result"}, result, eres);
    check({name, "_err"}, err, eerr);
    check({name, "_depth"}, depth, dexp(edep));
    check({name, "_strobes"}, seq, eseq);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  imm;
    logic [7:0]  res;
    logic        err;
    int          lat;
    int          dep;
    logic [15:0] seq;
  } vec_t;

  // Strobe codes, oldest first: 1 push, 2 pop, 3 tos.
  localparam logic [15:0] S_BIN = 16'h0029, S_NOT = 16'h0009, S_POP = 16'h0002,
                          S_TOS = 16'h0003, S_PSH = 16'h0001, S_NON = 16'h0000;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{3'b100, 8'h05, 8'h05, 1'b0, 2, 1, S_PSH};
    vecs[1]  = '{3'b100, 8'h03, 8'h03, 1'b0, 2, 2, S_PSH};
    vecs[2]  = '{3'b000, 8'h00, 8'h08, 1'b0, 5, 1, S_BIN};
    vecs[3]  = '{3'b100, 8'h02, 8'h02, 1'b0, 2, 2, S_PSH};
    vecs[4]  = '{3'b100, 8'h07, 8'h07, 1'b0, 2, 3, S_PSH};
    vecs[5]  = '{3'b001, 8'h00, 8'hFB, 1'b0, 5, 2, S_BIN};
    vecs[6]  = '{3'b110, 8'h00, 8'hFB, 1'b0, 3, 2, S_TOS};
    vecs[7]  = '{3'b101, 8'h00, 8'hFB, 1'b0, 3, 1, S_POP};
    vecs[8]  = '{3'b100, 8'hF0, 8'hF0, 1'b0, 2, 2, S_PSH};
    vecs[9]  = '{3'b011, 8'h00, 8'h0F, 1'b0, 4, 2, S_NOT};
    vecs[10] = '{3'b010, 8'h00, 8'h08, 1'b0, 5, 1, S_BIN};
    vecs[11] = '{3'b101, 8'h00, 8'h08, 1'b0, 3, 0, S_POP};
    vecs[12] = '{3'b111, 8'h55, 8'h08, 1'b1, 1, 0, S_NON};
    vecs[13] = '{3'b100, 8'hAA, 8'hAA, 1'b0, 2, 1, S_PSH};

    repeat (2) @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 14; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].imm, 1'b0,
              vecs[i].res, vecs[i].err, vecs[i].lat, vecs[i].dep, vecs[i].seq);

    // start held while busy with a different op must be ignored
    run_cmd("busy_poke", 3'b100, 8'h11, 1'b1, 8'h11, 1'b0, 2, 2, S_PSH);
    run_cmd("reserved", 3'b111, 8'h00, 1'b0, 8'h11, 1'b1, 1, 2, S_NON);

    // reset in the POP2 cycle of an ADD
    @(negedge clk);
    start = 1'b1; op_i = 3'b000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    begin
      int d0;
      d0 = n_done;
      @(negedge clk);
      check_idle("abort");
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_no_done", n_done, d0);
    end
    run_cmd("after_abort", 3'b100, 8'h3C, 1'b0, 8'h3C, 1'b0, 2, 1, S_PSH);

`ifdef STACK_SEQ_DEPTH_CHECK_EN
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    run_cmd("underflow_add", 3'b000, 8'h00, 1'b0, 8'h00, 1'b1, 1, 0, S_NON);
    for (int i = 0; i < 32; i++)
      run_cmd($sformatf("fill%0d", i), 3'b100, 8'(i), 1'b0, 8'(i), 1'b0, 2, i + 1, S_PSH);
    run_cmd("overflow", 3'b100, 8'hEE, 1'b0, 8'h1F, 1'b1, 1, 32, S_NON);
    run_cmd("pop_full", 3'b101, 8'h00, 1'b0, 8'h1F, 1'b0, 3, 31, S_POP);
`endif

    repeat (2) @(negedge clk);
    check("protocol_violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
